// File: rtl/sched_pkg.sv
// Shared types and constants for the register file write scheduler.
// Defines the writeback source enum and the {rd, data} request struct.
package sched_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_scheduler_arb.sv
// wb_arb2: two-requester writeback arbiter, one-hot grant_alu/grant_mem,
// plus any_grant. SCHED_RR_EN selects round-robin (adds clock/reset_n).
module wb_arb2
  import sched_pkg::*;
(
`ifdef SCHED_RR_EN
  input  logic clock,
  input  logic reset_n,
`endif
  input  logic alu_valid,
  input  logic mem_valid,
  output logic grant_alu,
  output logic grant_mem,
  output logic any_grant
);

  logic mem_first;
  logic mem_win;
  logic alu_win;

`ifdef SCHED_RR_EN
  wb_src_e last_q;

  // mem has the tie only if the ALU was granted last.
  assign mem_first = (last_q == WB_SRC_ALU);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= WB_SRC_ALU;
    end else if (any_grant) begin
      last_q <= grant_mem ? WB_SRC_MEM
                          : WB_SRC_ALU;
    end
  end
`else
  assign mem_first = 1'b1;
`endif

  assign mem_win = mem_valid &
                   (mem_first | ~alu_valid);
  assign alu_win = alu_valid & ~mem_win;

  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    unique case (1'b1)
      mem_win: grant_mem = 1'b1;
      alu_win: grant_alu = 1'b1;
      default: ;
    endcase
  end

  assign any_grant = grant_alu | grant_mem;

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register file write port between ALU and load writeback,
// drives a registered wr_en/wr_rd/wr_data stage and a load busy scoreboard.
// Ports: clock, reset_n (async low); alu_*/mem_* valid/ready sources;
// issue_valid/issue_rd load issue; rs1/rs2 -> rs1_busy/rs2_busy;
// wr_en/wr_rd/wr_data to the register file. Option: SCHED_RR_EN.
module regfile_write_scheduler
  import sched_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEFAULT,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            wr_en,
  output logic [AW-1:0]   wr_rd,
  output logic [XLEN-1:0] wr_data
);

  logic grant_alu;
  logic grant_mem;
  logic any_grant;

  wb_arb2 u_arb (
`ifdef SCHED_RR_EN
    .clock     (clock),
    .reset_n   (reset_n),
`endif
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .grant_alu (grant_alu),
    .grant_mem (grant_mem),
    .any_grant (any_grant)
  );

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  assign win_rd   = grant_mem ? mem_rd : alu_rd;
  assign win_data = grant_mem ? mem_data : alu_data;

  wb_src_e wr_src_q;
  logic    wr_src_mem;

  assign wr_src_mem = (wr_src_q == WB_SRC_MEM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_en    <= 1'b0;
      wr_rd    <= '0;
      wr_data  <= '0;
      wr_src_q <= WB_SRC_ALU;
    end else if (any_grant) begin
      wr_en    <= (win_rd != '0);
      wr_rd    <= win_rd;
      wr_data  <= win_data;
      wr_src_q <= grant_mem ? WB_SRC_MEM
                            : WB_SRC_ALU;
    end else begin
      wr_en <= 1'b0;
    end
  end

  logic [NREGS-1:1] busy_q;
  logic [NREGS-1:1] busy_set;
  logic [NREGS-1:1] busy_clr;
  logic [NREGS-1:0] busy_full;

  // Clear on the edge the register file commits the load data,
  // so busy drops exactly when the new value becomes readable.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    for (int i = 1; i < NREGS; i++) begin
      busy_set[i] = issue_valid &&
                    (issue_rd == AW'(i));
      busy_clr[i] = wr_en && wr_src_mem &&
                    (wr_rd == AW'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~busy_clr) | busy_set;
    end
  end

  assign busy_full = {busy_q, 1'b0};
  assign rs1_busy  = busy_full[rs1];
  assign rs2_busy  = busy_full[rs2];

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: expected writes queued,
// a negedge monitor pops and compares every wr_en pulse in order.
module tb_regfile_write_scheduler;
  import sched_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;

  regfile_write_scheduler dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .alu_ready   (alu_ready),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .wr_en       (wr_en),
    .wr_rd       (wr_rd),
    .wr_data     (wr_data)
  );

  always #5 clock = ~clock;

  int      n_cmp = 0;
  int      n_bad = 0;
  wb_req_t sb[$];
  wb_req_t exp_w;
  logic [31:0] rf [32];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [4:0] rd,
                      input logic [31:0] data);
    wb_req_t e;
    e.rd   = rd;
    e.data = data;
    sb.push_back(e);
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[wr_rd] <= wr_data;
    end
  end

  always @(negedge clock) begin
    if (reset_n && wr_en) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected none",
                 wr_rd, wr_data);
      end else begin
        exp_w = sb.pop_front();
        chk("wr_rd", {27'd0, wr_rd}, {27'd0, exp_w.rd});
        chk("wr_data", wr_data, exp_w.data);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_rd", {27'd0, wr_rd}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("rst_rs2_busy", {31'd0, rs2_busy}, 32'd0);

    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    #1;
    chk("alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("mem_ready_idle", {31'd0, mem_ready}, 32'd0);
    push(5'd5, 32'hDEADBEEF);
    tick();
    alu_valid = 1'b0;
    chk("wr_en_n1", {31'd0, wr_en}, 32'd1);
    tick();
    chk("wr_en_n2", {31'd0, wr_en}, 32'd0);

    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    alu_data  = 32'h11;
    mem_valid = 1'b1;
    mem_rd    = 5'd4;
    mem_data  = 32'h22;
    #1;
    chk("c1_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("c1_alu_ready", {31'd0, alu_ready}, 32'd0);
    push(5'd4, 32'h22);
    tick();
    mem_rd   = 5'd6;
    mem_data = 32'h66;
    #1;
`ifdef SCHED_RR_EN
    chk("c2_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("c2_mem_ready", {31'd0, mem_ready}, 32'd0);
    push(5'd3, 32'h11);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("c3_mem_ready", {31'd0, mem_ready}, 32'd1);
    push(5'd6, 32'h66);
    tick();
    mem_valid = 1'b0;
`else
    chk("c2_mem_ready", {31'd0, mem_ready}, 32'd1);
    chk("c2_alu_ready", {31'd0, alu_ready}, 32'd0);
    push(5'd6, 32'h66);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("c3_alu_ready", {31'd0, alu_ready}, 32'd1);
    push(5'd3, 32'h11);
    tick();
    alu_valid = 1'b0;
`endif
    tick();

    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    rs1         = 5'd7;
    rs2         = 5'd7;
    tick();
    issue_valid = 1'b0;
    chk("ld_rs1_busy", {31'd0, rs1_busy}, 32'd1);
    chk("ld_rs2_busy", {31'd0, rs2_busy}, 32'd1);
    mem_valid = 1'b1;
    mem_rd    = 5'd7;
    mem_data  = 32'h55;
    #1;
    chk("ld_mem_ready", {31'd0, mem_ready}, 32'd1);
    push(5'd7, 32'h55);
    tick();
    mem_valid = 1'b0;
    chk("ld_busy_n1", {31'd0, rs1_busy}, 32'd1);
    tick();
    chk("ld_busy_n2", {31'd0, rs1_busy}, 32'd0);
    chk("ld_rf7", rf[7], 32'h55);

    mem_valid = 1'b1;
    mem_rd    = 5'd0;
    mem_data  = 32'h99;
    #1;
    chk("x0_mem_ready", {31'd0, mem_ready}, 32'd1);
    tick();
    mem_valid = 1'b0;
    chk("x0_wr_en", {31'd0, wr_en}, 32'd0);
    tick();
    chk("hold_wr_rd", {27'd0, wr_rd}, 32'd0);
    chk("hold_wr_data", wr_data, 32'h99);
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    rs1         = 5'd0;
    rs2         = 5'd0;
    tick();
    issue_valid = 1'b0;
    chk("x0_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("x0_rs2_busy", {31'd0, rs2_busy}, 32'd0);

    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    rs1         = 5'd9;
    tick();
    issue_valid = 1'b0;
    mem_valid   = 1'b1;
    mem_rd      = 5'd9;
    mem_data    = 32'h90;
    push(5'd9, 32'h90);
    tick();
    mem_valid   = 1'b0;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    chk("setwin_busy9", {31'd0, rs1_busy}, 32'd1);
    tick();
    chk("setwin_busy9_hold", {31'd0, rs1_busy}, 32'd1);
    mem_valid = 1'b1;
    mem_data  = 32'h91;
    push(5'd9, 32'h91);
    tick();
    mem_valid = 1'b0;
    tick();
    chk("clr_busy9", {31'd0, rs1_busy}, 32'd0);
    chk("clr_rf9", rf[9], 32'h91);

    issue_valid = 1'b1;
    issue_rd    = 5'd10;
    rs1         = 5'd10;
    tick();
    issue_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_rd      = 5'd10;
    alu_data    = 32'hA0;
    push(5'd10, 32'hA0);
    tick();
    alu_valid = 1'b0;
    tick();
    tick();
    chk("alu_noclr_busy", {31'd0, rs1_busy}, 32'd1);
    chk("sb_drained", sb.size(), 32'd0);

    alu_valid = 1'b1;
    alu_rd    = 5'd12;
    alu_data  = 32'hC0;
    push(5'd12, 32'hC0);
    tick();
    alu_valid = 1'b0;
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("mid_rst_wr_rd", {27'd0, wr_rd}, 32'd0);
    chk("mid_rst_wr_data", wr_data, 32'd0);
    chk("mid_rst_busy", {31'd0, rs1_busy}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy", {31'd0, rs1_busy}, 32'd0);
    chk("post_rst_wr_en", {31'd0, wr_en}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Schedules the register file's single write port between the ALU and load/memory writeback sources, and keeps a scoreboard of registers with outstanding loads. Sits between execute/memory stages and the register file: drives the register file's `rd`/`data`/`reg_write` inputs from a registered output stage. Decode reads its busy flags to stall dependent instructions.

## Interface
- `XLEN`, 32: data width.
- `NREGS`, 32: architectural registers; address width is `$clog2(NREGS)`.

- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU has a result to write.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `mem_valid`  in  1  load data available.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  XLEN  load data.
- `mem_ready`  out  1  load result accepted this cycle.
- `issue_valid`  in  1  a load is issued this cycle.
- `issue_rd`  in  5  destination of the issued load.
- `rs1`, `rs2`  in  5 each  decode source addresses.
- `rs1_busy`, `rs2_busy`  out  1 each  source has an outstanding load.
- `wr_en`  out  1  to register file `reg_write`.
- `wr_rd`  out  5  to register file `rd`.
- `wr_data`  out  XLEN  to register file `data`.

## Operation
- Handshake per source: transfer occurs when `valid & ready` in the same cycle. Source holds `rd`/`data` stable while `valid & !ready`. `ready` is combinational from the `valid` inputs and arbiter state. At most one `ready` is high per cycle.
- Arbitration, default: fixed priority, mem over ALU. `ready` is high for the winner whenever any `valid` is high. There is no downstream backpressure.
- Output stage: on an accepted transfer, `wr_rd`/`wr_data` load the winner's fields. `wr_en` is set to 1 if `rd != 0`, otherwise 0.
- Write to x0: accepted normally (ready high) but produces `wr_en = 0`. It never affects the scoreboard.
- No transfer in a cycle: `wr_en` goes to 0; `wr_rd`/`wr_data` hold their values.
- A `wr_src_mem` flag is registered alongside the output stage.
- Scoreboard is `busy[NREGS-1:1]`:
  - `issue_valid & issue_rd != 0` sets `busy[issue_rd]`.
  - `wr_en & wr_src_mem` clears `busy[wr_rd]`. This is the same edge the register file commits the data.
  - Set and clear of the same register in one cycle: set wins.
  - ALU writes never clear busy bits.
- `rsN_busy = busy[rsN]`, combinational. It is 0 for `rsN == 0`.
- Reset values: `wr_en` 0, `wr_rd` 0, `wr_data` 0, all `busy` 0, `wr_src_mem` 0, round-robin pointer = ALU-last.
- Reset asserted mid-operation: all state is cleared immediately. In-flight output writes are dropped.

## Timing
- Accept at edge N → `wr_en`/`wr_rd`/`wr_data` valid during cycle N+1 → register file commits at edge N+1 → read data is visible in cycle N+2.
- The busy bit for a load drops in the same cycle its data becomes readable (cycle N+2). Decode never sees busy=0 with stale data.
- Throughput: one write per cycle. The losing source waits; under fixed priority its wait is unbounded while mem stays valid.
- `issue_valid` at edge N → `rsN_busy` high from cycle N+1.

## Configuration
- `SCHED_RR_EN`, defined: two-way round-robin arbitration.
  - A 1-bit pointer records the last granted source and updates on every transfer.
  - On contention, the source not granted last wins; the ALU-last reset value means mem wins the first tie.
  - Worst-case wait is 1 cycle.
- `SCHED_RR_EN`, undefined: fixed mem-over-ALU priority. No pointer flop is present.

## Structure
- Shared package `sched_pkg`:
  - `XLEN_DEFAULT` and `REG_ADDR_W` (5) constants.
  - `wb_src_e` enum {`WB_SRC_ALU`, `WB_SRC_MEM`}.
  - Packed struct `wb_req_t` {rd, data}.
- One sub-module: `wb_arb2`, two-requester arbiter producing one-hot grants.
  - Contains the `SCHED_RR_EN` pointer logic.
  - Outputs: `grant_alu`, `grant_mem`, `any_grant`.
- The scoreboard and output stage live in the top module.

## Test plan
- Reset release, no traffic → `wr_en`=0, `wr_rd`=0, `wr_data`=0, `rs1_busy`=`rs2_busy`=0.
- `alu_valid`, rd=5, data=0xDEADBEEF at edge N → `alu_ready`=1 in that cycle; cycle N+1 `wr_en`=1, `wr_rd`=5, `wr_data`=0xDEADBEEF; cycle N+2 `wr_en`=0.
- Both valid (alu rd=3/0x11, mem rd=4/0x22) held for 2 cycles:
  - Fixed priority: mem write first, then ALU.
  - With `SCHED_RR_EN`: mem first; on re-contention the next tie goes to ALU.
- Issue load rd=7; `rs1`=7 → `rs1_busy`=1 from the next cycle. Mem returns rd=7/0x55 at edge N → `rs1_busy` still 1 in cycle N+1 and 0 in cycle N+2, when the register file reads 0x55.
- `mem_valid` with rd=0 → `mem_ready`=1, `wr_en` stays 0. Issue with rd=0 → no busy change; `rs1`=0 reads not busy.
- Same-cycle clear of `busy[9]` (mem write commits rd=9) and new issue rd=9 → `busy[9]` remains 1. Also: `reset_n` pulsed low mid-burst → all outputs and busy bits 0 immediately, without waiting for a clock edge.
